// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared defaults for the sync_fifo slice: default word width, default
//   pointer width and a helper that turns a pointer width into a depth.
//   No ports; imported by the interface, the storage array and the top.
package sync_fifo_pkg;

  localparam int default_data_width = 8;
  localparam int default_addr_width = 4;

  // Number of entries addressable by a pointer of the given width.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if
//   Groups the producer/consumer handshake of sync_fifo into one bundle.
//   Signals:
//     wr_en, wr_data : write request and the word to store
//     rd_en          : read request
//     rd_data        : registered read data
//     full, empty    : occupancy flags
//   Modports:
//     master : the side that uses the FIFO (drives requests, sees status)
//     slave  : the FIFO itself
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int data_width = default_data_width
) ();

  logic                  wr_en;
  logic [data_width-1:0] wr_data;
  logic                  rd_en;
  logic [data_width-1:0] rd_data;
  logic                  full;
  logic                  empty;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, full, empty
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
//   Simple dual-port register array with one write port and one registered
//   read port. Storage itself is never reset; only the read register is.
//   Ports:
//     clk     : clock, rising edge
//     rst_n   : asynchronous active-low reset (clears rd_data only)
//     we      : write enable
//     wr_addr : write address
//     wr_data : word to write
//     re      : read enable, loads rd_data from rd_addr
//     rd_addr : read address
//     rd_data : registered read data, holds when re is low
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int data_width = default_data_width,
  parameter int addr_width = default_addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  re,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data
);

  localparam int depth = depth_of(addr_width);

  logic [data_width-1:0] mem [depth];

  // Storage array: no reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: the FIFO never reads and writes the same slot in one
  // cycle, so old-data-on-collision semantics are never relied upon.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock synchronous FIFO with full/empty flags and a registered
//   read port (data appears the cycle after an accepted read).
//   Ports:
//     clk   : clock, all state updates on the rising edge
//     rst_n : asynchronous active-low reset; empties the FIFO at once
//     bus   : sync_fifo_if.slave (wr_en, wr_data, rd_en, rd_data, full, empty)
//   Parameters:
//     data_width : bits per word
//     addr_width : pointer width
//     data_depth : entries, must equal 2**addr_width
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int data_width = default_data_width,
  parameter int addr_width = default_addr_width,
  parameter int data_depth = depth_of(addr_width)
) (
  input logic        clk,
  input logic        rst_n,
  sync_fifo_if.slave bus
);

  localparam int count_width = addr_width + 1;
  localparam logic [addr_width-1:0]  ptr_one   = 1;
  localparam logic [count_width-1:0] count_one = 1;
  localparam logic [count_width-1:0] count_max = count_width'(data_depth);

  logic [addr_width-1:0]  wr_ptr;
  logic [addr_width-1:0]  rd_ptr;
  logic [count_width-1:0] count;
  logic                   wr_acc;
  logic                   rd_acc;

  // Flags come straight from count so they never lag it. A write is refused
  // when full and a read when empty, which also keeps the two ports from
  // touching the same slot in the same cycle.
  assign bus.empty = (count == '0);
  assign bus.full  = (count == count_max);
  assign wr_acc    = bus.wr_en & ~bus.full;
  assign rd_acc    = bus.rd_en & ~bus.empty;

  // Pointers wrap naturally at data_depth because data_depth == 2**addr_width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
    end
  end

  // Occupancy: a simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + count_one;
        2'b01:   count <= count - count_one;
        default: count <= count;
      endcase
    end
  end

  sync_fifo_mem #(
    .data_width (data_width),
    .addr_width (addr_width)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .re      (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
//   Self-checking bench for sync_fifo. A queue holds the words the FIFO
//   should contain; each clock the bench decides from the queue size which
//   requests are accepted and what rd_data must show afterwards.
module tb_sync_fifo;

  localparam int data_width = 8;
  localparam int addr_width = 4;
  localparam int data_depth = 16;

  logic clk = 1'b0;
  logic rst_n;

  sync_fifo_if #(.data_width(data_width)) bus ();

  sync_fifo #(
    .data_width (data_width),
    .addr_width (addr_width),
    .data_depth (data_depth)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [data_width-1:0] model_q [$];
  logic [data_width-1:0] exp_rd;
  int total_checks  = 0;
  int passed_checks = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end else begin
      passed_checks++;
    end
  endtask

  // Compare all visible outputs against the reference queue.
  task automatic checkState(input string tag);
    checkOutput({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
    checkOutput({tag, "_empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    checkOutput({tag, "_full"}, 32'(bus.full), 32'(model_q.size() == data_depth));
  endtask

  // Drive one cycle of requests, advance the model across the edge, then
  // sample the DUT 1 ns after the edge.
  task automatic applyStimulus(input string tag, input logic wr,
                               input logic [data_width-1:0] data, input logic rd);
    bit wr_ok;
    bit rd_ok;
    bus.wr_en   = wr;
    bus.wr_data = data;
    bus.rd_en   = rd;
    @(posedge clk);
    wr_ok = wr && (model_q.size() < data_depth);
    rd_ok = rd && (model_q.size() > 0);
    if (rd_ok) exp_rd = model_q.pop_front();
    if (wr_ok) model_q.push_back(data);
    #1;
    checkState(tag);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    exp_rd      = '0;

    // 1. Reset then idle
    #2;
    checkState("reset");
    #5;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("idle", 1'b0, 8'h00, 1'b0);

    // 2. Fill 0..15, then a dropped write of 0xAA
    for (int i = 0; i < data_depth; i++) applyStimulus("fill", 1'b1, 8'(i), 1'b0);
    checkOutput("fill_full_const", 32'(bus.full), 32'd1);
    applyStimulus("fill_drop", 1'b1, 8'hAA, 1'b0);

    // 3. Drain 0..15, then a read while empty leaves rd_data at 15
    for (int i = 0; i < data_depth; i++) begin
      applyStimulus("drain", 1'b0, 8'h00, 1'b1);
      checkOutput("drain_val", 32'(bus.rd_data), 32'(i));
    end
    checkOutput("drain_empty_const", 32'(bus.empty), 32'd1);
    applyStimulus("drain_extra", 1'b0, 8'h00, 1'b1);
    checkOutput("drain_hold", 32'(bus.rd_data), 32'd15);

    // 4. Wrap-around: offset the pointers first so the 10 writes cross the end
    for (int i = 0; i < 8; i++) applyStimulus("offset_wr", 1'b1, 8'(200 + i), 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus("offset_rd", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus("wrap_wr", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("wrap_rd", 1'b0, 8'h00, 1'b1);
      checkOutput("wrap_first", 32'(bus.rd_data), 32'(i));
    end
    applyStimulus("wrap_wr2", 1'b1, 8'd88, 1'b0);
    applyStimulus("wrap_wr2", 1'b1, 8'd11, 1'b0);
    applyStimulus("wrap_wr2", 1'b1, 8'd12, 1'b0);
    begin
      logic [data_width-1:0] wrap_exp [10];
      wrap_exp = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd88, 8'd11, 8'd12};
      for (int i = 0; i < 10; i++) begin
        applyStimulus("wrap_rd", 1'b0, 8'h00, 1'b1);
        checkOutput("wrap_order", 32'(bus.rd_data), 32'(wrap_exp[i]));
      end
    end

    // 5. Simultaneous read+write at count 5
    for (int i = 0; i < 5; i++) applyStimulus("mid_fill", 1'b1, 8'(50 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("mid_both", 1'b1, 8'd33, 1'b1);
      checkOutput("mid_oldest", 32'(bus.rd_data), 32'(50 + i));
    end
    applyStimulus("mid_drain", 1'b0, 8'h00, 1'b1);
    checkOutput("mid_last_old", 32'(bus.rd_data), 32'd54);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("mid_drain", 1'b0, 8'h00, 1'b1);
      checkOutput("mid_33", 32'(bus.rd_data), 32'd33);
    end

    // 6a. Read+write while empty: only the write lands, no bypass
    applyStimulus("empty_both", 1'b1, 8'h5A, 1'b1);
    checkOutput("empty_both_hold", 32'(bus.rd_data), 32'd33);
    checkOutput("empty_both_nonempty", 32'(bus.empty), 32'd0);
    applyStimulus("empty_both_rd", 1'b0, 8'h00, 1'b1);
    checkOutput("empty_both_val", 32'(bus.rd_data), 32'h5A);

    // 6b. Read+write while full: read returns oldest, write dropped
    for (int i = 0; i < data_depth; i++) applyStimulus("full_fill", 1'b1, 8'(100 + i), 1'b0);
    applyStimulus("full_both", 1'b1, 8'h77, 1'b1);
    checkOutput("full_both_val", 32'(bus.rd_data), 32'd100);
    checkOutput("full_both_notfull", 32'(bus.full), 32'd0);
    for (int i = 1; i < data_depth; i++) begin
      applyStimulus("full_drain", 1'b0, 8'h00, 1'b1);
      checkOutput("full_drain_val", 32'(bus.rd_data), 32'(100 + i));
    end
    checkOutput("full_drain_empty", 32'(bus.empty), 32'd1);

    // Reset mid-operation discards contents immediately
    for (int i = 0; i < 3; i++) applyStimulus("pre_reset", 1'b1, 8'(i + 1), 1'b0);
    applyStimulus("pre_reset_rd", 1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;
    model_q.delete();
    exp_rd = '0;
    #1;
    checkState("async_reset");
    #2;
    rst_n = 1'b1;
    applyStimulus("post_reset", 1'b0, 8'h00, 1'b1);

    // Randomized traffic with phase-varying write/read pressure
    for (int i = 0; i < 600; i++) begin
      int phase;
      int wr_pct;
      int rd_pct;
      phase  = (i / 75) % 4;
      wr_pct = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      rd_pct = (phase == 0) ? 20 : (phase == 1) ? 80 : (phase == 2) ? 50 : 95;
      applyStimulus("random",
                    ($urandom_range(99) < wr_pct),
                    8'($urandom),
                    ($urandom_range(99) < rd_pct));
    end

    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
